fabric_row_sequencer: RTL and testbench

- Per-row instruction sequencer that sits between the host/loader and the west edge of the cell fabric.
- Buffers instruction words per row, streams them onto the row's instruction daisy chain on command, then issues a call pulse and tracks completion via the row's ret line, with timeout.
- Generalises single-word, combinational row injection to ROWS independent buffered channels with handshake, status and error reporting.

---
 rtl/fabric_row_sequencer_pkg.sv | 26 ++
 rtl/fabric_seq_fifo.sv | 59 +++++
 rtl/fabric_row_sequencer.sv | 158 +++++++++++++++
 tb/tb_fabric_row_sequencer.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_row_sequencer_pkg.sv
// Shared types and default sizing for the per-row fabric instruction sequencer.
package fabric_row_sequencer_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 6;
    localparam int DEF_HOPS_WIDTH     = 4;
    localparam int DEF_FIFO_DEPTH     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    localparam int CNT_WIDTH = $clog2(DEF_FIFO_DEPTH) + 1;
    localparam int TO_WIDTH  = $clog2(DEF_TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CALL,
        WAIT_RET
    } seq_state_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_HOPS_WIDTH-1:0] hops;
    } instr_entry_t;

endpackage

// File: rtl/fabric_seq_fifo.sv
// Single-clock instruction FIFO, one per fabric row; show-ahead read of the head entry.
module fabric_seq_fifo
    import fabric_row_sequencer_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  instr_entry_t wr_entry,
    input  logic         pop,
    output instr_entry_t rd_entry,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    instr_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign rd_entry = mem[rd_ptr];

    // Storage is data-only and needs no reset; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fabric_row_sequencer.sv
// Per-row buffered instruction streamer for the fabric west edge: load, issue, call, await ret.
module fabric_row_sequencer
    import fabric_row_sequencer_pkg::*;
#(
    parameter int ROWS             = 2,
    parameter int COLS             = 2,
    parameter int INSTR_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int INSTR_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int INSTR_HOPS_WIDTH = DEF_HOPS_WIDTH,
    parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
    localparam int CW              = $clog2(FIFO_DEPTH) + 1,
    localparam int TW              = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ROWS-1:0]                        ld_valid,
    output logic [ROWS-1:0]                        ld_ready,
    input  logic [ROWS-1:0][INSTR_DATA_WIDTH-1:0]  ld_data,
    input  logic [ROWS-1:0][INSTR_ADDR_WIDTH-1:0]  ld_addr,
    input  logic [ROWS-1:0][INSTR_HOPS_WIDTH-1:0]  ld_hops,
    input  logic [ROWS-1:0]                        start,
    output logic [ROWS-1:0]                        busy,
    output logic [ROWS-1:0]                        done,
    output logic [ROWS-1:0]                        timeout,
    output logic [ROWS-1:0]                        drop_err,
    output logic [ROWS-1:0][CW-1:0]                fifo_count,
    output logic [ROWS-1:0][INSTR_DATA_WIDTH-1:0]  instr_data_out,
    output logic [ROWS-1:0][INSTR_ADDR_WIDTH-1:0]  instr_addr_out,
    output logic [ROWS-1:0][INSTR_HOPS_WIDTH-1:0]  instr_hops_out,
    output logic [ROWS-1:0]                        instr_en_out,
    output logic [ROWS-1:0]                        call,
    input  logic [ROWS-1:0]                        ret
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        seq_state_t    state;
        logic [TW-1:0] to_cnt;
        logic          ret_q;
        logic          done_q;
        logic          timeout_q;
        logic          drop_q;
        logic          call_q;
        logic          en_q;
        instr_entry_t  out_q;
        instr_entry_t  wr_entry;
        instr_entry_t  head;
        logic          full;
        logic          empty;
        logic [CW-1:0] count;
        logic          accept;
        logic          hops_ok;
        logic          push;
        logic          pop;
        logic          start_ok;
        logic          ret_rise;
        logic          to_hit;

        assign ld_ready[r] = !full && (state != ISSUE);
        assign accept      = ld_valid[r] && ld_ready[r];
        assign hops_ok     = int'(ld_hops[r]) < COLS;
        assign push        = accept && hops_ok;
        assign wr_entry    = '{data: ld_data[r], addr: ld_addr[r], hops: ld_hops[r]};

        // The last busy cycle coincides with the done/timeout pulse, so start is held off there too.
        assign start_ok = start[r] && (state == IDLE) && !done_q && !timeout_q;
        // The first pop happens on the start edge itself so the stream begins without a bubble.
        assign pop      = !empty && (start_ok || (state == ISSUE));
        assign ret_rise = ret[r] && !ret_q;
        assign to_hit   = (TIMEOUT_CYCLES != 0) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

        fabric_seq_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push),
            .wr_entry (wr_entry),
            .pop      (pop),
            .rd_entry (head),
            .full     (full),
            .empty    (empty),
            .count    (count)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                state     <= IDLE;
                to_cnt    <= '0;
                ret_q     <= 1'b0;
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
                drop_q    <= 1'b0;
                call_q    <= 1'b0;
                en_q      <= 1'b0;
                out_q     <= '0;
            end else begin
                ret_q     <= ret[r];
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
                call_q    <= 1'b0;
                drop_q    <= accept && !hops_ok;
                en_q      <= pop;
                if (pop) begin
                    out_q <= head;
                end
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            if (!empty) begin
                                state <= ISSUE;
                            end else begin
                                state  <= CALL;
                                call_q <= 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        if (empty) begin
                            state  <= CALL;
                            call_q <= 1'b1;
                        end
                    end
                    CALL: begin
                        state  <= WAIT_RET;
                        to_cnt <= '0;
                    end
                    WAIT_RET: begin
                        if (ret_rise) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                            to_cnt <= '0;
                        end else if (to_hit) begin
                            timeout_q <= 1'b1;
                            state     <= IDLE;
                            to_cnt    <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign busy[r]           = (state != IDLE) || done_q || timeout_q;
        assign done[r]           = done_q;
        assign timeout[r]        = timeout_q;
        assign drop_err[r]       = drop_q;
        assign fifo_count[r]     = count;
        assign instr_data_out[r] = out_q.data;
        assign instr_addr_out[r] = out_q.addr;
        assign instr_hops_out[r] = out_q.hops;
        assign instr_en_out[r]   = en_q;
        assign call[r]           = call_q;
    end

endmodule

// File: tb/tb_fabric_row_sequencer.sv
// Scenario bench for fabric_row_sequencer with a per-row scoreboard of issued instruction words.
module tb_fabric_row_sequencer;

    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int HW    = 4;
    localparam int DEPTH = 8;
    localparam int TO    = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [ROWS-1:0]           ld_valid;
    logic [ROWS-1:0]           ld_ready;
    logic [ROWS-1:0][DW-1:0]   ld_data;
    logic [ROWS-1:0][AW-1:0]   ld_addr;
    logic [ROWS-1:0][HW-1:0]   ld_hops;
    logic [ROWS-1:0]           start;
    logic [ROWS-1:0]           busy;
    logic [ROWS-1:0]           done;
    logic [ROWS-1:0]           timeout;
    logic [ROWS-1:0]           drop_err;
    logic [ROWS-1:0][CW-1:0]   fifo_count;
    logic [ROWS-1:0][DW-1:0]   instr_data_out;
    logic [ROWS-1:0][AW-1:0]   instr_addr_out;
    logic [ROWS-1:0][HW-1:0]   instr_hops_out;
    logic [ROWS-1:0]           instr_en_out;
    logic [ROWS-1:0]           call;
    logic [ROWS-1:0]           ret;

    int errors = 0;
    int checks = 0;

    logic [DW+AW+HW-1:0] sbq [ROWS][$];
    logic [DW+AW+HW-1:0] mon_exp;
    logic [DW+AW+HW-1:0] mon_got;

    fabric_row_sequencer #(
        .ROWS             (ROWS),
        .COLS             (COLS),
        .INSTR_DATA_WIDTH (DW),
        .INSTR_ADDR_WIDTH (AW),
        .INSTR_HOPS_WIDTH (HW),
        .FIFO_DEPTH       (DEPTH),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_data        (ld_data),
        .ld_addr        (ld_addr),
        .ld_hops        (ld_hops),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .drop_err       (drop_err),
        .fifo_count     (fifo_count),
        .instr_data_out (instr_data_out),
        .instr_addr_out (instr_addr_out),
        .instr_hops_out (instr_hops_out),
        .instr_en_out   (instr_en_out),
        .call           (call),
        .ret            (ret)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Every issued word must match the oldest word loaded on that row.
    always @(posedge clk) begin
        #1;
        for (int r = 0; r < ROWS; r++) begin
            if (instr_en_out[r] === 1'b1) begin
                checks++;
                mon_got = {instr_data_out[r], instr_addr_out[r], instr_hops_out[r]};
                if (sbq[r].size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected row%0d: got issued word %h, required no issue", r, mon_got);
                end else begin
                    mon_exp = sbq[r].pop_front();
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL sb_word row%0d: got %h, required %h", r, mon_got, mon_exp);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int r, input logic [DW-1:0] d, input logic [AW-1:0] a, input logic [HW-1:0] h);
        ld_valid[r] = 1'b1;
        ld_data[r]  = d;
        ld_addr[r]  = a;
        ld_hops[r]  = h;
        checks++;
        if (ld_ready[r] !== 1'b1) begin
            errors++;
            $display("FAIL load_ready row%0d: got %b, required 1", r, ld_ready[r]);
        end
        if (int'(h) < COLS) sbq[r].push_back({d, a, h});
        step();
        ld_valid[r] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (ld_ready !== 2'b11) begin
            errors++;
            $display("FAIL reset_ld_ready: got %b, required 11", ld_ready);
        end
        checks++;
        if ({busy, done, timeout, drop_err, instr_en_out, call} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required all zero", {busy, done, timeout, drop_err, instr_en_out, call});
        end
        checks++;
        if ({fifo_count, instr_data_out, instr_addr_out, instr_hops_out} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h, required zero", {fifo_count, instr_data_out, instr_addr_out, instr_hops_out});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_issue();
        load(0, 32'hA000_0001, 6'd5, 4'd0);
        load(0, 32'hB000_0002, 6'd9, 4'd1);
        load(0, 32'hC000_0003, 6'd63, 4'd1);
        checks++;
        if (fifo_count[0] !== 4'd3) begin
            errors++;
            $display("FAIL issue_count: got %0d, required 3", fifo_count[0]);
        end
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (instr_en_out[0] !== 1'b1 || call[0] !== 1'b0 || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL issue_en beat%0d: got en=%b call=%b busy=%b, required en=1 call=0 busy=1",
                         i, instr_en_out[0], call[0], busy[0]);
            end
            step();
        end
        checks++;
        if (call[0] !== 1'b1 || instr_en_out[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL issue_call: got call=%b en=%b busy=%b, required call=1 en=0 busy=1",
                     call[0], instr_en_out[0], busy[0]);
        end
        checks++;
        if (instr_data_out[0] !== 32'hC000_0003) begin
            errors++;
            $display("FAIL issue_hold: got %h, required c0000003", instr_data_out[0]);
        end
        step();
        checks++;
        if (call[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL issue_call_width: got call=%b busy=%b, required call=0 busy=1", call[0], busy[0]);
        end
    endtask

    task automatic test_done();
        ret[0] = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL done_early: got done=%b busy=%b, required done=0 busy=1", done[0], busy[0]);
        end
        ret[0] = 1'b1;
        step();
        checks++;
        if (done[0] !== 1'b1 || busy[0] !== 1'b1 || timeout[0] !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b busy=%b timeout=%b, required 1 1 0", done[0], busy[0], timeout[0]);
        end
        step();
        checks++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL done_after: got done=%b busy=%b, required 0 0", done[0], busy[0]);
        end
        ret[0] = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        step();
        for (int i = 1; i <= TO; i++) begin
            step();
            if (i < TO) begin
                if (timeout[0] !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout_early cycle%0d: got 1, required 0", i);
                end
            end else begin
                checks++;
                if (timeout[0] !== 1'b1 || busy[0] !== 1'b1 || done[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_pulse: got timeout=%b busy=%b done=%b, required 1 1 0",
                             timeout[0], busy[0], done[0]);
                end
            end
        end
        step();
        checks++;
        if (timeout[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got timeout=%b busy=%b, required 0 0", timeout[0], busy[0]);
        end
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        checks++;
        if (call[0] !== 1'b1 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_restart: got call=%b busy=%b, required 1 1", call[0], busy[0]);
        end
        step();
        ret[0] = 1'b1;
        step();
        checks++;
        if (done[0] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_restart_done: got %b, required 1", done[0]);
        end
        ret[0] = 1'b0;
        step();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            load(1, $urandom, 6'($urandom), 4'($urandom_range(0, COLS - 1)));
        end
        checks++;
        if (fifo_count[1] !== 4'd8 || ld_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got count=%0d ready=%b, required 8 0", fifo_count[1], ld_ready[1]);
        end
        ld_valid[1] = 1'b1;
        ld_data[1]  = 32'hDEAD_BEEF;
        ld_hops[1]  = 4'd0;
        step();
        step();
        ld_valid[1] = 1'b0;
        checks++;
        if (fifo_count[1] !== 4'd8) begin
            errors++;
            $display("FAIL fill_overflow: got count=%0d, required 8", fifo_count[1]);
        end
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (instr_en_out[1] !== 1'b1 || ld_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL fill_drain beat%0d: got en=%b ready=%b, required en=1 ready=0",
                         i, instr_en_out[1], ld_ready[1]);
            end
            step();
        end
        checks++;
        if (instr_en_out[1] !== 1'b0 || call[1] !== 1'b1 || fifo_count[1] !== 4'd0) begin
            errors++;
            $display("FAIL fill_call: got en=%b call=%b count=%0d, required 0 1 0",
                     instr_en_out[1], call[1], fifo_count[1]);
        end
        ret[1] = 1'b1;
        step();
        step();
        checks++;
        if (done[1] !== 1'b0 || busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL ret_level_on_entry: got done=%b busy=%b, required 0 1", done[1], busy[1]);
        end
        ret[1] = 1'b0;
        step();
        ret[1] = 1'b1;
        step();
        checks++;
        if (done[1] !== 1'b1) begin
            errors++;
            $display("FAIL fill_done: got %b, required 1", done[1]);
        end
        ret[1] = 1'b0;
        step();
        checks++;
        if (busy[1] !== 1'b0 || sbq[1].size() != 0) begin
            errors++;
            $display("FAIL fill_drained: got busy=%b pending=%0d, required 0 0", busy[1], sbq[1].size());
        end
    endtask

    task automatic test_drop();
        load(0, 32'h1234_5678, 6'd1, 4'd2);
        checks++;
        if (drop_err[0] !== 1'b1 || fifo_count[0] !== 4'd0) begin
            errors++;
            $display("FAIL drop_pulse: got drop=%b count=%0d, required 1 0", drop_err[0], fifo_count[0]);
        end
        load(0, 32'h1111_2222, 6'd2, 4'd15);
        checks++;
        if (drop_err[0] !== 1'b1 || fifo_count[0] !== 4'd0) begin
            errors++;
            $display("FAIL drop_max: got drop=%b count=%0d, required 1 0", drop_err[0], fifo_count[0]);
        end
        step();
        checks++;
        if (drop_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL drop_width: got %b, required 0", drop_err[0]);
        end
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        checks++;
        if (call[0] !== 1'b1 || instr_en_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL empty_start_call: got call=%b en=%b, required 1 0", call[0], instr_en_out[0]);
        end
        step();
        checks++;
        if (call[0] !== 1'b0 || instr_en_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL empty_start_after: got call=%b en=%b, required 0 0", call[0], instr_en_out[0]);
        end
        ret[0] = 1'b1;
        step();
        ret[0] = 1'b0;
        checks++;
        if (done[0] !== 1'b1) begin
            errors++;
            $display("FAIL empty_start_done: got %b, required 1", done[0]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic seen;
        for (int i = 0; i < 2; i++) load(0, 32'h0A00_0000 + i, 6'(i), 4'(i % COLS));
        for (int i = 0; i < 4; i++) load(1, 32'h0B00_0000 + i, 6'(10 + i), 4'((i + 1) % COLS));
        start = 2'b11;
        step();
        start = 2'b00;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (instr_en_out[0] !== (i < 2) || instr_en_out[1] !== 1'b1 || call[0] !== (i == 2)) begin
                errors++;
                $display("FAIL b2b_beat%0d: got en=%b call0=%b, required en0=%b en1=1 call0=%b",
                         i, instr_en_out, call[0], (i < 2), (i == 2));
            end
            if (i < 2) step();
        end
        rst = 1'b1;
        step();
        checks++;
        if (ld_ready !== 2'b11 || {busy, done, timeout, drop_err, instr_en_out, call} !== '0) begin
            errors++;
            $display("FAIL midrun_reset_ctrl: got ready=%b ctrl=%b, required 11 and zero",
                     ld_ready, {busy, done, timeout, drop_err, instr_en_out, call});
        end
        checks++;
        if ({fifo_count, instr_data_out, instr_addr_out, instr_hops_out} !== '0) begin
            errors++;
            $display("FAIL midrun_reset_data: got %h, required zero",
                     {fifo_count, instr_data_out, instr_addr_out, instr_hops_out});
        end
        for (int r = 0; r < ROWS; r++) sbq[r].delete();
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < TO + 4; i++) begin
            step();
            if ((done | timeout | instr_en_out | call | busy) !== 2'b00) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_quiet: got activity after reset, required none");
        end
    endtask

    initial begin
        rst      = 1'b1;
        ld_valid = '0;
        ld_data  = '0;
        ld_addr  = '0;
        ld_hops  = '0;
        start    = '0;
        ret      = '0;
        test_reset();
        test_issue();
        test_done();
        test_timeout();
        test_fill();
        test_drop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
